// File: rtl/axi_read_responder_pkg.sv
// -----------------------------------------------------------------------------
// axi_resp_pkg
//   Shared types for the AXI read responder: FSM state encoding, the queued
//   AR request entry, and the channel field widths.
//   The bus widths come from the `ADDR_WIDTH / `DATA_WIDTH macros (32 bits
//   when not supplied by the build).
//   Optional feature macro used by the responder: AXI_RESP_LATENCY_EN.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axi_resp_pkg;

  localparam int AR_ID_WIDTH    = 4;
  localparam int AR_LEN_WIDTH   = 8;
  localparam int AXI_ADDR_WIDTH = `ADDR_WIDTH;
  localparam int AXI_DATA_WIDTH = `DATA_WIDTH;
  // Word address as stored in the queue: byte address without its two LSBs.
  // The responder keeps only the low MEM_INDEX_WIDTH bits of it.
  localparam int AR_WORD_WIDTH  = AXI_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    FETCH  = 2'd2,
    STREAM = 2'd3
  } resp_state_t;

  typedef struct packed {
    logic [AR_WORD_WIDTH-1:0] addr;
    logic [AR_LEN_WIDTH-1:0]  beats;
    logic [AR_ID_WIDTH-1:0]   id;
  } ar_entry_t;

endpackage

// File: rtl/axi_read_responder_if.sv
// -----------------------------------------------------------------------------
// axi_read_address / axi_read_data
//   Read-address and read-data channel bundles. The responder connects to the
//   slave modports; caches (or a testbench) drive the master side.
// -----------------------------------------------------------------------------
interface axi_read_address;
  import axi_resp_pkg::*;
  logic [AXI_ADDR_WIDTH-1:0] ARADDR;
  logic [AR_LEN_WIDTH-1:0]   ARLEN;
  logic [AR_ID_WIDTH-1:0]    ARID;
  logic                      ARVALID;
  logic                      ARREADY;

  modport slave  (input ARADDR, ARLEN, ARID, ARVALID, output ARREADY);
  modport master (output ARADDR, ARLEN, ARID, ARVALID, input ARREADY);
endinterface

interface axi_read_data;
  import axi_resp_pkg::*;
  logic [AXI_DATA_WIDTH-1:0] RDATA;
  logic [AR_ID_WIDTH-1:0]    RID;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  modport slave  (output RDATA, RID, RLAST, RVALID, input RREADY);
  modport master (input RDATA, RID, RLAST, RVALID, output RREADY);
endinterface

// File: rtl/axi_read_responder_fifo.sv
// -----------------------------------------------------------------------------
// ar_request_fifo
//   Circular buffer of pending AR requests with full/empty flags. Push and pop
//   may happen in the same cycle. Callers only push when !full and only pop
//   when !empty.
//   Ports: clk, rst (async, active-high), push/push_data, pop/pop_data
//   (head entry, valid when !empty), full, empty.
// -----------------------------------------------------------------------------
module ar_request_fifo #(
  parameter int  QUEUE_DEPTH = 2,
  parameter type entry_t     = axi_resp_pkg::ar_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_s, do_pop_s;

  // Explicit wrap so a depth-1 queue never indexes past its single slot.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QUEUE_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/axi_read_responder_ram.sv
// -----------------------------------------------------------------------------
// cache_bank
//   Single-clock word RAM with one write port and one synchronous read port.
//   The read output register only updates when re is high, so it holds its
//   value otherwise. A same-cycle write and read of one word returns the old
//   word (read-before-write). Contents are not reset.
//   Ports: clk, we/waddr/wdata (write), re/raddr (read), rdata (registered).
// -----------------------------------------------------------------------------
module cache_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  assign rdata = rdata_q;

  // Write and registered read; nonblocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/axi_read_responder.sv
// -----------------------------------------------------------------------------
// axi_read_responder
//   AXI-style read slave: queues AR requests and answers each with one
//   incrementing burst read from an internal word RAM, honouring RREADY
//   backpressure. The RAM can be preloaded through the init port.
//   Ports: clk, rst (async, active-high), mem_read_address (AR slave),
//   mem_read_data (R slave), init_we/init_addr/init_wdata (preload).
//   Macro AXI_RESP_LATENCY_EN: adds a WAIT state of LATENCY cycles before
//   every burst.
// -----------------------------------------------------------------------------
module axi_read_responder
  import axi_resp_pkg::*;
#(
  parameter int MEM_INDEX_WIDTH = 16,
  parameter int QUEUE_DEPTH     = 2,
  parameter int LATENCY         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_read_address.slave             mem_read_address,
  axi_read_data.slave                mem_read_data,
  input  logic                       init_we,
  input  logic [MEM_INDEX_WIDTH-1:0] init_addr,
  input  logic [AXI_DATA_WIDTH-1:0]  init_wdata
);

  resp_state_t                state_q, state_d;
  logic [MEM_INDEX_WIDTH-1:0] addr_q, addr_d;
  logic [AR_LEN_WIDTH-1:0]    beats_q, beats_d;
  logic [AR_ID_WIDTH-1:0]     id_q, id_d;

  ar_entry_t                  ar_entry_s, fifo_head_s, start_entry_s;
  logic                       fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
  logic                       arready_s, ar_hs_s, bypass_s;
  logic                       ram_re_s;
  logic [MEM_INDEX_WIDTH-1:0] ram_raddr_s;
  logic [AXI_DATA_WIDTH-1:0]  ram_rdata_s;
  logic                       rvalid_s;
  logic                       unused_s;

`ifdef AXI_RESP_LATENCY_EN
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
`else
  localparam int unused_latency = LATENCY;
`endif

  // Byte-lane bits and RAM-index overflow bits are intentionally dropped.
  assign unused_s = ^{mem_read_address.ARADDR, fifo_head_s.addr};

  assign arready_s = !fifo_full_s && !rst;
  assign ar_hs_s   = mem_read_address.ARVALID && arready_s;
  assign mem_read_address.ARREADY = arready_s;

  // Normalise the incoming request; a zero length still yields one beat.
  always_comb begin
    ar_entry_s.addr  = AR_WORD_WIDTH'(mem_read_address.ARADDR[2 +: MEM_INDEX_WIDTH]);
    ar_entry_s.beats = (mem_read_address.ARLEN == 8'd0) ? 8'd1 : mem_read_address.ARLEN;
    ar_entry_s.id    = mem_read_address.ARID;
  end

  // An idle responder with an empty queue takes a new request straight from
  // the bus, so the first beat appears two cycles after the handshake.
  assign start_entry_s = fifo_empty_s ? ar_entry_s : fifo_head_s;
  assign fifo_push_s   = ar_hs_s && !bypass_s;

  ar_request_fifo #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .entry_t     (ar_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (ar_entry_s),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  cache_bank #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .ADDR_WIDTH (MEM_INDEX_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (init_we),
    .waddr (init_addr),
    .wdata (init_wdata),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Burst FSM: next state, burst bookkeeping and RAM read control.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    id_d        = id_q;
    fifo_pop_s  = 1'b0;
    bypass_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_raddr_s = addr_q;
`ifdef AXI_RESP_LATENCY_EN
    lat_cnt_d   = lat_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s || ar_hs_s) begin
          fifo_pop_s = !fifo_empty_s;
          bypass_s   = fifo_empty_s;
          addr_d     = start_entry_s.addr[MEM_INDEX_WIDTH-1:0];
          beats_d    = start_entry_s.beats;
          id_d       = start_entry_s.id;
`ifdef AXI_RESP_LATENCY_EN
          if (LATENCY > 0) begin
            state_d   = WAIT;
            lat_cnt_d = LAT_W'(LATENCY - 1);
          end else begin
            state_d = FETCH;
          end
`else
          state_d = FETCH;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef AXI_RESP_LATENCY_EN
      WAIT: begin
        if (lat_cnt_q == {LAT_W{1'b0}}) begin
          state_d = FETCH;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
          state_d   = WAIT;
        end
      end
`endif
      FETCH: begin
        ram_re_s    = 1'b1;
        ram_raddr_s = addr_q;
        state_d     = STREAM;
      end
      STREAM: begin
        // Without a handshake the RAM is not re-read, keeping RDATA stable.
        if (mem_read_data.RREADY) begin
          if (beats_q == 8'd1) begin
            state_d = IDLE;
          end else begin
            beats_d     = beats_q - 8'd1;
            addr_d      = addr_q + MEM_INDEX_WIDTH'(1);
            ram_re_s    = 1'b1;
            ram_raddr_s = addr_q + MEM_INDEX_WIDTH'(1);
            state_d     = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and burst registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= {MEM_INDEX_WIDTH{1'b0}};
      beats_q <= 8'd0;
      id_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      id_q    <= id_d;
    end
  end

`ifdef AXI_RESP_LATENCY_EN
  // Pre-burst latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_q <= {LAT_W{1'b0}};
    end else begin
      lat_cnt_q <= lat_cnt_d;
    end
  end
`endif

  assign rvalid_s              = (state_q == STREAM);
  assign mem_read_data.RVALID  = rvalid_s;
  assign mem_read_data.RDATA   = rvalid_s ? ram_rdata_s : {AXI_DATA_WIDTH{1'b0}};
  assign mem_read_data.RID     = id_q;
  assign mem_read_data.RLAST   = rvalid_s && (beats_q == 8'd1);

endmodule

// File: tb/tb_axi_read_responder.sv
module tb_axi_read_responder;
  import axi_resp_pkg::*;

  localparam int MIW       = 8;
  localparam int QD        = 2;
  localparam int LAT       = 4;
  localparam int MEM_WORDS = 1 << MIW;
`ifdef AXI_RESP_LATENCY_EN
  localparam int LAT_OFF = LAT;
`else
  localparam int LAT_OFF = 0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           init_we = 1'b0;
  logic [MIW-1:0] init_addr = '0;
  logic [31:0]    init_wdata = 32'd0;
  logic           rready_fix = 1'b1;
  logic           rand_rdy = 1'b0;
  logic           rnd_rdy = 1'b1;

  int    checks = 0;
  int    errors = 0;
  int    cycle = 0;
  int    hs_count = 0;
  beat_t exp_q[$];
  logic [31:0] model_mem [MEM_WORDS];

  axi_read_address ar_if ();
  axi_read_data    rd_if ();

  assign rd_if.RREADY = rand_rdy ? rnd_rdy : rready_fix;

  axi_read_responder #(
    .MEM_INDEX_WIDTH (MIW),
    .QUEUE_DEPTH     (QD),
    .LATENCY         (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read_address (ar_if),
    .mem_read_data    (rd_if),
    .init_we          (init_we),
    .init_addr        (init_addr),
    .init_wdata       (init_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cycle);
    $fatal(1, "watchdog");
  end

  // Monitor: every presented beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && rd_if.RVALID) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stray_beat: got RDATA=%h RID=%0d RLAST=%0b, required no beat",
                 rd_if.RDATA, rd_if.RID, rd_if.RLAST);
      end else begin
        if (rd_if.RDATA !== exp_q[0].data || rd_if.RID !== exp_q[0].id ||
            rd_if.RLAST !== exp_q[0].last) begin
          errors++;
          $display("FAIL beat: got data=%h id=%0d last=%0b, required data=%h id=%0d last=%0b",
                   rd_if.RDATA, rd_if.RID, rd_if.RLAST, exp_q[0].data, exp_q[0].id, exp_q[0].last);
        end
        if (rd_if.RREADY) begin
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    init_we    = 1'b1;
    init_addr  = addr[MIW-1:0];
    init_wdata = data;
    model_mem[addr % MEM_WORDS] = data;
    tick();
    init_we = 1'b0;
  endtask

  // Reference: a burst reads consecutive words, wrapping at the top of RAM.
  task automatic push_expect(input logic [31:0] addr, input int len, input logic [3:0] id);
    int    beats;
    int    word;
    beat_t b;
    beats = (len == 0) ? 1 : len;
    word  = int'(addr / 4) % MEM_WORDS;
    for (int i = 0; i < beats; i++) begin
      b.data = model_mem[(word + i) % MEM_WORDS];
      b.id   = id;
      b.last = (i == beats - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_ar(input logic [31:0] addr, input int len, input logic [3:0] id,
                         output int hs_cyc);
    bit done;
    done   = 1'b0;
    hs_cyc = -1;
    ar_if.ARADDR  = addr;
    ar_if.ARLEN   = len[7:0];
    ar_if.ARID    = id;
    ar_if.ARVALID = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (ar_if.ARREADY) begin
        push_expect(addr, len, id);
        hs_cyc = cycle;
        done   = 1'b1;
      end
      tick();
    end
    ar_if.ARVALID = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout: got no ARREADY for id %0d, required acceptance", id);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 2000 && exp_q.size() > 0; n++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    int h1, h2, h3, h4, h0;
    ar_if.ARADDR  = 32'd0;
    ar_if.ARLEN   = 8'd0;
    ar_if.ARID    = 4'd0;
    ar_if.ARVALID = 1'b0;

    // Reset values.
    repeat (3) tick();
    chk("rst_rvalid",  {31'd0, rd_if.RVALID},  32'd0);
    chk("rst_rlast",   {31'd0, rd_if.RLAST},   32'd0);
    chk("rst_rid",     {28'd0, rd_if.RID},     32'd0);
    chk("rst_rdata",   rd_if.RDATA,            32'd0);
    chk("rst_arready", {31'd0, ar_if.ARREADY}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_arready", {31'd0, ar_if.ARREADY}, 32'd1);

    // Preload: random background, then the known pattern at words 0x40..0x43.
    for (int i = 0; i < MEM_WORDS; i++) write_word(i, $urandom);
    for (int i = 0; i < 4; i++) write_word(32'h40 + i, 32'hA0 + i);

    // Basic 4-beat burst with first-beat timing.
    rready_fix = 1'b1;
    send_ar(32'h100, 4, 4'd2, h1);
    for (int k = 0; k <= LAT_OFF; k++) begin
      chk("first_beat_early", {31'd0, rd_if.RVALID}, 32'd0);
      tick();
    end
    chk("first_beat_on_time", {31'd0, rd_if.RVALID}, 32'd1);
    chk("first_beat_data", rd_if.RDATA, 32'hA0);
    wait_drain("basic");

    // Backpressure: hold RREADY low for 3 cycles after the first beat.
    rready_fix = 1'b0;
    send_ar(32'h100, 4, 4'd2, h1);
    for (int n = 0; n < 50 && !rd_if.RVALID; n++) tick();
    for (int k = 0; k < 3; k++) begin
      chk("stall_rdata", rd_if.RDATA, 32'hA0);
      tick();
    end
    rready_fix = 1'b1;
    wait_drain("backpressure");

    // Wrap at the top of RAM, then a zero-length request.
    send_ar(32'h3FC, 2, 4'd7, h1);
    wait_drain("wrap");
    send_ar(32'h104, 0, 4'd9, h1);
    wait_drain("zero_len");

    // Queue full: one burst in flight plus QD queued; the next must stall.
    rready_fix = 1'b0;
    send_ar(32'h100, 2, 4'd1, h1);
    send_ar(32'h108, 2, 4'd2, h2);
    send_ar(32'h110, 2, 4'd3, h3);
    chk("full_hs_2", h2, h1 + 1);
    chk("full_hs_3", h3, h2 + 1);
    ar_if.ARADDR  = 32'h120;
    ar_if.ARLEN   = 8'd2;
    ar_if.ARID    = 4'd4;
    ar_if.ARVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_arready", {31'd0, ar_if.ARREADY}, 32'd0);
      tick();
    end
    rready_fix = 1'b1;
    send_ar(32'h120, 2, 4'd4, h4);
    wait_drain("queue_full");

    // Randomised traffic with random RREADY.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_ar($urandom, $urandom_range(0, 8), 4'($urandom_range(0, 15)), h1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
    end
    wait_drain("random");
    rand_rdy = 1'b0;
    rready_fix = 1'b1;

    // Reset during beat 2 of an 8-beat burst with another request queued.
    h0 = hs_count;
    send_ar(32'h200, 8, 4'd5, h1);
    send_ar(32'h300, 4, 4'd6, h2);
    for (int n = 0; n < 50 && hs_count < h0 + 1; n++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", {31'd0, rd_if.RVALID}, 32'd0);
    chk("midrst_arready", {31'd0, ar_if.ARREADY}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_release_arready", {31'd0, ar_if.ARREADY}, 32'd1);
    repeat (30) tick();
    send_ar(32'h100, 4, 4'd3, h1);
    wait_drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
